// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared constants and types for the small CPU front end.
//   PC_W     : program counter / instruction memory address width
//   INSTR_W  : instruction width
//   CNT_W    : default width of the retired-instruction counter
//   fetch_state_t : fetch sequencer states (idle, pipeline fill, running)
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 16;

  // Width of the branch target supplied by the branch unit.
  localparam int BR_ADDR_W = 9;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_FILL = 2'd1,
    FS_RUN  = 2'd2
  } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Program counter and instruction fetch stage. Drives a synchronous-read
//   instruction memory (data returns one cycle after the address) and presents
//   one instruction per cycle to decode. Redirects on a taken branch and
//   squashes the wrong-path fetch, honours decode stall, stops on HALT and
//   counts retired instructions (saturating).
//
// Ports
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   start         : pulse, begin execution at start_pc (only acted on in idle)
//   start_pc      : first fetch address
//   stall         : decode not ready; hold presented instruction, no new fetch
//   branch        : taken-branch decision for the presented instruction
//   branch_addr   : branch target, zero-extended to PC_W
//   halt_instr    : presented instruction is HALT
//   imem_addr     : instruction memory read address
//   imem_rdata    : instruction memory data for the previous cycle's address
//   instr         : instruction to decode
//   instr_pc      : address of instr
//   instr_valid   : instr / instr_pc meaningful
//   busy          : sequencer not idle
//   done          : one-cycle pulse in the cycle HALT retires
//   retired       : instructions retired since the last start
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int CNT_W   = cpu_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [PC_W-1:0]      start_pc,
  input  logic                 stall,
  input  logic                 branch,
  input  logic [8:0]           branch_addr,
  input  logic                 halt_instr,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]   imem_rdata,
  output logic [INSTR_W-1:0]   instr,
  output logic [PC_W-1:0]      instr_pc,
  output logic                 instr_valid,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     retired
);

  import cpu_pkg::*;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fetch_state_t          state;
  logic [PC_W-1:0]       pc;          // address of the fetch being issued
  logic [PC_W-1:0]       instr_pc_q;  // address of the fetch now returning
  logic                  instr_valid_q;
  logic [CNT_W-1:0]      retired_q;

  // While decode stalls, the memory keeps reading pc (the *next* instruction),
  // so the presented instruction has to be held locally. instr_q captures the
  // memory output on the first stalled cycle; hold_q selects it afterwards.
  logic [INSTR_W-1:0]    instr_q;
  logic                  hold_q;

  // ---------------------------------------------------------------------------
  // Decode of this cycle's decisions
  // ---------------------------------------------------------------------------
  logic                  retire;
  logic                  take_halt;
  logic                  take_branch;
  logic [PC_W-1:0]       pc_next;

  // NOTE: every signal assigned in always_comb gets an unconditional default
  // first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    retire      = 1'b0;
    take_halt   = 1'b0;
    take_branch = 1'b0;
    pc_next     = pc + PC_W'(1);
    done        = 1'b0;

    // instr_valid is only ever set in RUN, so it alone qualifies a retire.
    // branch/halt_instr are meaningless unless an instruction retires.
    retire      = instr_valid_q && !stall;
    take_halt   = retire && halt_instr;
    // HALT has priority: no redirect when both are asserted.
    take_branch = retire && branch && !halt_instr;

    if (take_branch) begin
      pc_next = PC_W'(branch_addr);
    end

    done = take_halt;
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FS_IDLE;
      pc            <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      retired_q     <= '0;
      instr_q       <= '0;
      hold_q        <= 1'b0;
    end else begin
      // Stall holding of the presented instruction.
      if (stall) begin
        if (!hold_q) begin
          instr_q <= imem_rdata;
        end
        hold_q <= 1'b1;
      end else begin
        hold_q <= 1'b0;
      end

      case (state)
        FS_IDLE: begin
          if (start) begin
            state     <= FS_FILL;
            pc        <= start_pc;
            retired_q <= '0;
          end
        end

        // First address is on the bus; its data returns next cycle.
        FS_FILL: begin
          if (!stall) begin
            state         <= FS_RUN;
            pc            <= pc_next;
            instr_pc_q    <= pc;
            instr_valid_q <= 1'b1;
          end
        end

        FS_RUN: begin
          if (!stall) begin
            if (take_halt) begin
              state         <= FS_IDLE;
              instr_valid_q <= 1'b0;
            end else begin
              pc            <= pc_next;
              instr_pc_q    <= pc;
              // On a taken branch the fetch returning next cycle is the
              // fall-through instruction: present it as a bubble.
              instr_valid_q <= !take_branch;
            end

            if (retire && (retired_q != '1)) begin
              retired_q <= retired_q + CNT_W'(1);
            end
          end
        end

        default: begin
          state         <= FS_IDLE;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_addr   = pc;
  assign instr       = hold_q ? instr_q : imem_rdata;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign busy        = (state != FS_IDLE);
  assign retired     = retired_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. Instance "a" uses the default parameters;
//   instance "b" uses a 4-bit retired counter to reach saturation quickly.
//   Each instance has its own synchronous-read instruction memory whose
//   contents are a fixed function of the address.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;

  logic clk;
  logic rst_n;

  // Instance a
  logic               start_a, stall_a, branch_a, halt_a;
  logic [PC_W-1:0]    start_pc_a;
  logic [8:0]         branch_addr_a;
  logic [PC_W-1:0]    imem_addr_a, instr_pc_a;
  logic [INSTR_W-1:0] imem_rdata_a, instr_a;
  logic               instr_valid_a, busy_a, done_a;
  logic [15:0]        retired_a;

  // Instance b
  logic               start_b;
  logic [PC_W-1:0]    start_pc_b;
  logic               zero_b;
  logic [8:0]         zero_addr_b;
  logic [PC_W-1:0]    imem_addr_b, instr_pc_b;
  logic [INSTR_W-1:0] imem_rdata_b, instr_b;
  logic               instr_valid_b, busy_b, done_b;
  logic [3:0]         retired_b;

  int total = 0;
  int bad   = 0;

  fetch_unit dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .start_pc(start_pc_a),
    .stall(stall_a), .branch(branch_a), .branch_addr(branch_addr_a),
    .halt_instr(halt_a), .imem_addr(imem_addr_a), .imem_rdata(imem_rdata_a),
    .instr(instr_a), .instr_pc(instr_pc_a), .instr_valid(instr_valid_a),
    .busy(busy_a), .done(done_a), .retired(retired_a)
  );

  fetch_unit #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .start_pc(start_pc_b),
    .stall(zero_b), .branch(zero_b), .branch_addr(zero_addr_b),
    .halt_instr(zero_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
    .instr(instr_b), .instr_pc(instr_pc_b), .instr_valid(instr_valid_b),
    .busy(busy_b), .done(done_b), .retired(retired_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] mem_val(input logic [PC_W-1:0] a);
    return a[8:0] ^ 9'h1A5;
  endfunction

  always @(posedge clk) imem_rdata_a <= mem_val(imem_addr_a);
  always @(posedge clk) imem_rdata_b <= mem_val(imem_addr_b);

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 0; stall_a = 0; branch_a = 0; halt_a = 0;
    start_pc_a = '0; branch_addr_a = '0;
    start_b = 0; start_pc_b = '0; zero_b = 0; zero_addr_b = '0;

    // ---- reset values ----
    #3;
    check("rst imem_addr", imem_addr_a, 0);
    check("rst instr_valid", instr_valid_a, 0);
    check("rst instr_pc", instr_pc_a, 0);
    check("rst busy", busy_a, 0);
    check("rst done", done_a, 0);
    check("rst retired", retired_a, 0);
    check("rst retired_b", retired_b, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- 1: sequential fetch from 0x010 ----
    start_pc_a = 10'h010; start_a = 1;
    tick(); start_a = 0;
    check("fill busy", busy_a, 1);
    check("fill valid", instr_valid_a, 0);
    check("fill imem_addr", imem_addr_a, 10'h010);
    tick();
    check("run1 valid", instr_valid_a, 1);
    check("run1 instr_pc", instr_pc_a, 10'h010);
    check("run1 instr", instr_a, mem_val(10'h010));
    check("run1 imem_addr", imem_addr_a, 10'h011);
    check("run1 retired", retired_a, 0);
    tick();
    check("run2 instr_pc", instr_pc_a, 10'h011);
    check("run2 imem_addr", imem_addr_a, 10'h012);
    check("run2 retired", retired_a, 1);
    tick();
    check("run3 instr_pc", instr_pc_a, 10'h012);
    check("run3 retired", retired_a, 2);

    // ---- 2: branch at 0x012 to 0x048 ----
    branch_a = 1; branch_addr_a = 9'h048;
    tick(); branch_a = 0;
    check("br bubble valid", instr_valid_a, 0);
    check("br imem_addr", imem_addr_a, 10'h048);
    check("br retired", retired_a, 3);
    tick();
    check("br tgt valid", instr_valid_a, 1);
    check("br tgt instr_pc", instr_pc_a, 10'h048);
    check("br tgt instr", instr_a, mem_val(10'h048));
    check("br tgt retired", retired_a, 3);
    tick();
    check("br seq instr_pc", instr_pc_a, 10'h049);
    check("br seq retired", retired_a, 4);
    branch_a = 1; branch_addr_a = 9'h020;
    tick(); branch_a = 0;
    check("br2 bubble", instr_valid_a, 0);
    check("br2 retired", retired_a, 5);
    tick();
    check("br2 instr_pc", instr_pc_a, 10'h020);

    // ---- 3: stall with pending branch at 0x020 ----
    stall_a = 1; branch_a = 1; branch_addr_a = 9'h048;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall instr_pc", instr_pc_a, 10'h020);
      check("stall valid", instr_valid_a, 1);
      check("stall instr", instr_a, mem_val(10'h020));
      check("stall imem_addr", imem_addr_a, 10'h021);
      check("stall retired", retired_a, 5);
    end
    stall_a = 0;
    tick(); branch_a = 0;
    check("unstall bubble", instr_valid_a, 0);
    check("unstall imem_addr", imem_addr_a, 10'h048);
    check("unstall retired", retired_a, 6);
    tick();
    check("unstall tgt pc", instr_pc_a, 10'h048);
    check("unstall tgt instr", instr_a, mem_val(10'h048));
    // plain stall, then resume sequentially
    stall_a = 1;
    tick(); tick();
    check("hold instr", instr_a, mem_val(10'h048));
    check("hold instr_pc", instr_pc_a, 10'h048);
    stall_a = 0;
    tick();
    check("resume instr_pc", instr_pc_a, 10'h049);
    check("resume instr", instr_a, mem_val(10'h049));
    check("resume retired", retired_a, 7);
    halt_a = 1;
    #1;
    check("halt1 done", done_a, 1);
    tick(); halt_a = 0;
    check("halt1 busy", busy_a, 0);
    check("halt1 done off", done_a, 0);
    check("halt1 retired", retired_a, 8);

    // ---- 4: 8 retires then HALT at 0x030, start/branch same cycle ----
    start_pc_a = 10'h028; start_a = 1;
    tick(); start_a = 0;
    check("r4 retired clr", retired_a, 0);
    check("r4 busy", busy_a, 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("r4 instr_pc", instr_pc_a, 32'h028 + i);
      check("r4 retired", retired_a, i);
      if (i == 3) begin
        start_a = 1; start_pc_a = 10'h100;
      end
      tick(); start_a = 0;
    end
    check("r4 halt pc", instr_pc_a, 10'h030);
    check("r4 pre retired", retired_a, 8);
    halt_a = 1; branch_a = 1; branch_addr_a = 9'h1FF;
    start_a = 1; start_pc_a = 10'h100;
    #1;
    check("r4 done", done_a, 1);
    tick(); halt_a = 0; branch_a = 0; start_a = 0;
    check("r4 done off", done_a, 0);
    check("r4 busy off", busy_a, 0);
    check("r4 retired", retired_a, 9);
    check("r4 valid off", instr_valid_a, 0);
    tick();
    check("r4 start ignored", busy_a, 0);

    // ---- 5: wrap at 0x3FF, then async reset mid-run ----
    start_pc_a = 10'h3FE; start_a = 1;
    tick(); start_a = 0;
    check("wrap fill addr", imem_addr_a, 10'h3FE);
    tick();
    check("wrap pc0", instr_pc_a, 10'h3FE);
    check("wrap addr1", imem_addr_a, 10'h3FF);
    tick();
    check("wrap pc1", instr_pc_a, 10'h3FF);
    check("wrap addr2", imem_addr_a, 10'h000);
    tick();
    check("wrap pc2", instr_pc_a, 10'h000);
    check("wrap instr", instr_a, mem_val(10'h000));
    check("wrap retired", retired_a, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mrst imem_addr", imem_addr_a, 0);
    check("mrst valid", instr_valid_a, 0);
    check("mrst instr_pc", instr_pc_a, 0);
    check("mrst busy", busy_a, 0);
    check("mrst done", done_a, 0);
    check("mrst retired", retired_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post rst busy", busy_a, 0);

    // ---- 6: saturation with 4-bit counter ----
    start_pc_b = 10'h000; start_b = 1;
    tick(); start_b = 0;
    tick();
    check("sat first", retired_b, 0);
    for (int n = 1; n <= 20; n++) begin
      tick();
      check("sat retired", retired_b, (n > 15) ? 15 : n);
    end
    check("sat busy", busy_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_unit
